// File: rtl/serial_subtractor4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor4_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor computing D = A - B - Bin, LSB first, with a start/done handshake.
module serial_subtractor4
  import serial_subtractor4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_d, bit_bout;
  logic             last_bit;

  full_subtractor u_slice (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .bin (br),
    .d   (bit_d),
    .bout(bit_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are captured on start so the caller is free to change A/B/Bin during the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a <= A;
            sh_b <= B;
            br   <= Bin;
            cnt  <= '0;
            D    <= '0;
          end
        end
        ST_RUN: begin
          br   <= bit_bout;
          D    <= {bit_d, D[WIDTH-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          cnt  <= cnt + 1'b1;
          if (last_bit) Bout <= bit_bout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Scoreboard bench for serial_subtractor4: stimulus pushes expected results, a monitor checks each done.
module tb_serial_subtractor4;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0;
  logic             Bin = 1'b0;
  logic             busy, done, Bout;
  logic [WIDTH-1:0] D;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  int   cyc        = 0;
  int   run_len    = 0;

  serial_subtractor4 #(.WIDTH(WIDTH), .CW(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .D    (D),
    .Bout (Bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops one expected result per done pulse and checks value, latency and busy length.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run_len = 0;
      if (done) check_output("done_in_reset", int'(done), 0);
    end else begin
      if (busy) run_len++;
      if (done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("D", int'(D), int'(e.d));
          check_output("Bout", int'(Bout), int'(e.bout));
          check_output("done_cycle", cyc, e.due);
          check_output("busy_cycles", run_len, WIDTH);
          check_output("busy_at_done", int'(busy), 0);
        end
        run_len = 0;
      end
    end
  end

  task automatic wait_idle();
    int budget = 100;
    while ((busy || done) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check_output("idle_timeout", 1, 0);
  endtask

  // Issues one operation; returns after the accepting edge (+1) with start released.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bin, input logic [WIDTH-1:0] exp_d,
                                input logic exp_bout, input bit push);
    exp_t e;
    wait_idle();
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.d = exp_d; e.bout = exp_bout; e.due = cyc + WIDTH;
      sb.push_back(e);
    end
  endtask

  initial begin
    int diff;
    int budget;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_D", int'(D), 0);
    check_output("reset_Bout", int'(Bout), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1);
    apply_stimulus(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b1);
    apply_stimulus(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Operand change plus a stray start during RUN must not disturb the result.
    apply_stimulus(4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0, 1'b1);
    @(posedge clk); #1;
    A = 4'b0000; B = 4'b1111; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-RUN abandons the operation without a done pulse.
    apply_stimulus(4'b0111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("midrun_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_output("midrun_rst_busy", int'(busy), 0);
    check_output("midrun_rst_D", int'(D), 0);
    check_output("midrun_rst_Bout", int'(Bout), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    apply_stimulus(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [WIDTH-1:0] a, b;
      logic             bin;
      a    = WIDTH'(i >> 5);
      b    = WIDTH'(i >> 1);
      bin  = i[0];
      diff = int'(a) - int'(b) - int'(bin);
      apply_stimulus(a, b, bin, WIDTH'(diff), diff < 0, 1'b1);
    end

    budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check_output("drain_timeout", sb.size(), 0);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
